// File: rtl/sipo_deser_if.sv
// Parallel-side valid/ready channel of the serial link receiver.
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output parallel_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  parallel_out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-word holding buffer and overrun flag.
// Build option: define SIPO_LSB_FIRST_EN to take the first received bit as the LSB (default MSB-first).
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        serial_in,
    output logic        busy,
    output logic        overrun,
    sipo_deser_if.master out_if
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] word;
    logic             last_bit;
    logic             drain;

`ifdef SIPO_LSB_FIRST_EN
    assign word = {serial_in, sr_q[WIDTH-1:1]};
`else
    assign word = {sr_q[WIDTH-2:0], serial_in};
`endif

    assign last_bit = (cnt_q == CNT_LAST);
    assign drain    = valid_q && out_if.out_ready;

    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // The handshake runs every edge; a completion below may re-fill the buffer.
        if (drain) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            sr_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (shift_en) begin
            sr_d = word;
            if (last_bit) begin
                cnt_d = '0;
                if (!valid_q || drain) begin
                    hold_d  = word;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign out_if.parallel_out = hold_q;
    assign out_if.out_valid    = valid_q;
    assign busy                = busy_q;
    assign overrun             = overrun_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: framing, gaps, overrun, back-to-back drain, clear and reset.
module tb_sipo_deser;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    logic clear;
    logic shift_en;
    logic serial_in;
    logic busy;
    logic overrun;

    int total;
    int bad;

    sipo_deser_if #(.WIDTH(WIDTH)) bus ();

    sipo_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .busy      (busy),
        .overrun   (overrun),
        .out_if    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        step();
        shift_en  = 1'b0;
        serial_in = 1'b0;
    endtask

    // Bits go on the wire in index order 7..0 of w.
    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int gaps [8];
        logic [WIDTH-1:0] pat2;
        logic [WIDTH-1:0] exp2;

        total = 0;
        bad   = 0;
        rst = 1'b1; clear = 1'b0; shift_en = 1'b0; serial_in = 1'b0;
        bus.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_data", 32'(bus.parallel_out), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // Word 0xA5 back-to-back with consumer ready
        bus.out_ready = 1'b1;
        pat = 8'hA5;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i > 0) check("a5_busy", 32'(busy), 32'd1);
        end
        check("a5_valid", 32'(bus.out_valid), 32'd1);
        check("a5_data", 32'(bus.parallel_out), 32'hA5);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_overrun", 32'(overrun), 32'd0);
        step();
        check("a5_drained", 32'(bus.out_valid), 32'd0);
        $display("txn: 0xA5 contiguous");

        // Same word with idle gaps between strobes
        gaps = '{1, 0, 3, 2, 0, 1, 2, 3};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(pat[i]);
            for (int g = 0; g < gaps[i]; g++) begin
                step();
                if (i > 0) check("gap_busy", 32'(busy), 32'd1);
            end
        end
        // Last bit had 1 gap cycle with ready=1, so the word was already accepted.
        check("gap_drained", 32'(bus.out_valid), 32'd0);
        check("gap_data", 32'(bus.parallel_out), 32'hA5);
        $display("txn: 0xA5 with gaps");

        // Overrun: consumer stalled across two words
        bus.out_ready = 1'b0;
        send_word(8'h3C);
        check("ovr_first_valid", 32'(bus.out_valid), 32'd1);
        check("ovr_first_data", 32'(bus.parallel_out), 32'h3C);
        check("ovr_first_flag", 32'(overrun), 32'd0);
        send_word(8'hFF);
        check("ovr_hold_data", 32'(bus.parallel_out), 32'h3C);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("ovr_drain_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("ovr_sticky", 32'(overrun), 32'd1);
        $display("txn: 0x3C kept, 0xFF dropped");

        // Clear alone drops the overrun flag
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_overrun", 32'(overrun), 32'd0);

        // Drain on the same edge as completion
        send_word(8'h3C);
        check("b2b_first", 32'(bus.parallel_out), 32'h3C);
        pat = 8'h81;
        for (int i = WIDTH - 1; i >= 1; i--) send_bit(pat[i]);
        bus.out_ready = 1'b1;
        send_bit(pat[0]);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_data", 32'(bus.parallel_out), 32'h81);
        check("b2b_overrun", 32'(overrun), 32'd0);
        step();
        check("b2b_drained", 32'(bus.out_valid), 32'd0);
        $display("txn: 0x3C then 0x81 back-to-back");

        // Clear mid-word with a simultaneous strobe
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("clr_pre_busy", 32'(busy), 32'd1);
        clear = 1'b1; shift_en = 1'b1; serial_in = 1'b1;
        step();
        clear = 1'b0; shift_en = 1'b0; serial_in = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        send_word(8'h5A);
        check("clr_valid", 32'(bus.out_valid), 32'd1);
        check("clr_data", 32'(bus.parallel_out), 32'h5A);
        step();
        $display("txn: clear mid-word then 0x5A");

        // Reset mid-word
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        send_word(8'h5A);
        check("rst_mid_data", 32'(bus.parallel_out), 32'h5A);
        check("rst_mid_valid", 32'(bus.out_valid), 32'd1);
        step();
        $display("txn: reset mid-word then 0x5A");

        // Reset with a pending word
        bus.out_ready = 1'b0;
        send_word(8'h81);
        check("rst_pend_before", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_pend_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pend_data", 32'(bus.parallel_out), 32'h00);
        check("rst_pend_busy", 32'(busy), 32'd0);
        $display("txn: reset discards pending 0x81");

        // Bit order: wire sequence 1,1,0,0,0,0,0,0
        pat2 = 8'hC0;
`ifdef SIPO_LSB_FIRST_EN
        exp2 = 8'h03;
`else
        exp2 = 8'hC0;
`endif
        send_word(pat2);
        check("order_data", 32'(bus.parallel_out), 32'(exp2));
        check("order_valid", 32'(bus.out_valid), 32'd1);
        $display("txn: bit-order word 0x%0h", exp2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
